// File: rtl/kgp_pkg.sv
// Shared KGP_RISC decode definitions: opcodes, ALU function codes, instruction field positions
// and the decoded control bundle.
package kgp_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;

  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_LSB   = 16;
  localparam int unsigned FUNC_LSB = 0;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_ALUI = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_BR   = 6'h04;
  localparam logic [5:0] OP_BZ   = 6'h05;

  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_XOR = 6'h26;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [5:0]        alu_func;
    logic              use_imm;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              branch_z;
    logic              illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [INSTR_W-1:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[OP_LSB +: 6])
      OP_ALU: begin
        c.rd       = instr[RT_LSB +: REG_AW];
        c.alu_func = instr[FUNC_LSB +: 6];
      end
      OP_ALUI: begin
        c.rd       = instr[RT_LSB +: REG_AW];
        c.use_imm  = 1'b1;
        c.alu_func = FUNC_ADD;
      end
      OP_LD: begin
        c.rd     = instr[RT_LSB +: REG_AW];
        c.mem_rd = 1'b1;
      end
      OP_ST:   c.mem_wr   = 1'b1;
      OP_BR:   c.branch   = 1'b1;
      OP_BZ:   c.branch_z = 1'b1;
      default: c.illegal  = 1'b1;
    endcase
    return c;
  endfunction

  // Only ALU and ST actually consume rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_ALU) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: REG_NUM x DATA_W, two combinational read ports, one write port, r0 reads 0.
// Define KGP_WB_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module reg_file #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned AW      = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_NUM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef KGP_WB_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i != '0) && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/instr_decode.sv
// KGP_RISC decode stage: register read, immediate extension, control decode, load-use stall and
// the ID/EX pipeline register. KGP_WB_BYPASS_EN enables writeback-to-read bypass in reg_file.
module instr_decode
  import kgp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned REG_NUM = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               if_valid_i,
  input  logic [INSTR_W-1:0] if_instr_i,
  input  logic [ADDR_W-1:0]  if_npc_i,
  input  logic               ex_flush_i,
  input  logic               wb_we_i,
  input  logic [REG_AW-1:0]  wb_rd_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  output logic               id_stall_o,
  output logic               ex_valid_o,
  output logic [ADDR_W-1:0]  ex_npc_o,
  output logic [DATA_W-1:0]  ex_rs_data_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [DATA_W-1:0]  ex_imm_o,
  output logic [REG_AW-1:0]  ex_rd_o,
  output logic [5:0]         ex_alu_func_o,
  output logic               ex_use_imm_o,
  output logic               ex_mem_rd_o,
  output logic               ex_mem_wr_o,
  output logic               ex_branch_o,
  output logic               ex_branch_z_o,
  output logic [ADDR_W-1:0]  ex_br_target_o,
  output logic               ex_illegal_o
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] npc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
    logic [ADDR_W-1:0] br_target;
  } idex_t;

  idex_t idex_d, idex_q;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt;
  logic [DATA_W-1:0] rs_data, rt_data;

  assign op = if_instr_i[OP_LSB +: 6];
  assign rs = if_instr_i[RS_LSB +: REG_AW];
  assign rt = if_instr_i[RT_LSB +: REG_AW];

  reg_file #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM),
    .AW      (REG_AW)
  ) u_reg_file (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (wb_we_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

  // Load in EX whose result a source of the ID instruction needs; flush overrides the stall.
  assign id_stall_o = if_valid_i & idex_q.valid & idex_q.ctrl.mem_rd &
                      (idex_q.ctrl.rd != '0) &
                      ((idex_q.ctrl.rd == rs) | (uses_rt(op) & (idex_q.ctrl.rd == rt))) &
                      ~ex_flush_i;

  always_comb begin
    idex_d = '0;
    if (if_valid_i && !ex_flush_i && !id_stall_o) begin
      idex_d.valid     = 1'b1;
      idex_d.npc       = if_npc_i;
      idex_d.rs_data   = rs_data;
      idex_d.rt_data   = rt_data;
      idex_d.imm       = {{(DATA_W-16){if_instr_i[15]}}, if_instr_i[15:0]};
      idex_d.ctrl      = decode_ctrl(if_instr_i);
      idex_d.br_target = if_instr_i[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idex_q <= '0;
    else         idex_q <= idex_d;
  end

  assign ex_valid_o     = idex_q.valid;
  assign ex_npc_o       = idex_q.npc;
  assign ex_rs_data_o   = idex_q.rs_data;
  assign ex_rt_data_o   = idex_q.rt_data;
  assign ex_imm_o       = idex_q.imm;
  assign ex_rd_o        = idex_q.ctrl.rd;
  assign ex_alu_func_o  = idex_q.ctrl.alu_func;
  assign ex_use_imm_o   = idex_q.ctrl.use_imm;
  assign ex_mem_rd_o    = idex_q.ctrl.mem_rd;
  assign ex_mem_wr_o    = idex_q.ctrl.mem_wr;
  assign ex_branch_o    = idex_q.ctrl.branch;
  assign ex_branch_z_o  = idex_q.ctrl.branch_z;
  assign ex_br_target_o = idex_q.br_target;
  assign ex_illegal_o   = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed scenarios then randomized traffic, checked against
// a behavioural model of the decode stage and register file.
module tb_instr_decode;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [7:0]  if_npc_i;
  logic        ex_flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        id_stall_o, ex_valid_o;
  logic [7:0]  ex_npc_o, ex_br_target_o;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]  ex_rd_o;
  logic [5:0]  ex_alu_func_o;
  logic        ex_use_imm_o, ex_mem_rd_o, ex_mem_wr_o, ex_branch_o, ex_branch_z_o, ex_illegal_o;

  instr_decode dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .if_valid_i     (if_valid_i),
    .if_instr_i     (if_instr_i),
    .if_npc_i       (if_npc_i),
    .ex_flush_i     (ex_flush_i),
    .wb_we_i        (wb_we_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .id_stall_o     (id_stall_o),
    .ex_valid_o     (ex_valid_o),
    .ex_npc_o       (ex_npc_o),
    .ex_rs_data_o   (ex_rs_data_o),
    .ex_rt_data_o   (ex_rt_data_o),
    .ex_imm_o       (ex_imm_o),
    .ex_rd_o        (ex_rd_o),
    .ex_alu_func_o  (ex_alu_func_o),
    .ex_use_imm_o   (ex_use_imm_o),
    .ex_mem_rd_o    (ex_mem_rd_o),
    .ex_mem_wr_o    (ex_mem_wr_o),
    .ex_branch_o    (ex_branch_o),
    .ex_branch_z_o  (ex_branch_z_o),
    .ex_br_target_o (ex_br_target_o),
    .ex_illegal_o   (ex_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [7:0]  npc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic        use_imm, mem_rd, mem_wr, branch, branch_z;
    logic [7:0]  target;
    logic        illegal;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_ex;
  logic [31:0] m_rf[32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef KGP_WB_BYPASS_EN
    if (wb_we_i && wb_rd_i == r) return wb_data_i;
`endif
    return m_rf[r];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] ins, input logic [7:0] npc);
    exp_t        e;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm16;
    e = '{default: '0};
    op = ins[31:26];
    rt = ins[20:16];
    imm16 = ins[15:0];
    e.valid   = 1'b1;
    e.npc     = npc;
    e.rs_data = m_read(ins[25:21]);
    e.rt_data = m_read(rt);
    e.imm     = 32'($signed(imm16));
    e.target  = ins[7:0];
    case (op)
      6'd0: begin e.rd = rt; e.func = ins[5:0]; end
      6'd1: begin e.rd = rt; e.use_imm = 1'b1; e.func = 6'h20; end
      6'd2: begin e.rd = rt; e.mem_rd = 1'b1; end
      6'd3: e.mem_wr = 1'b1;
      6'd4: e.branch = 1'b1;
      6'd5: e.branch_z = 1'b1;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic bit m_stall(input bit v, input logic [31:0] ins, input bit fl);
    bit reads_rt;
    reads_rt = (ins[31:26] == 6'd0) || (ins[31:26] == 6'd3);
    return v && m_ex.valid && m_ex.mem_rd && (m_ex.rd != 5'd0) &&
           ((m_ex.rd == ins[25:21]) || (reads_rt && m_ex.rd == ins[20:16])) && !fl;
  endfunction

  // One pipeline cycle: drive at posedge+1, check stall, push the ID/EX contents due at the edge.
  task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit we,
                      input logic [4:0] rd, input logic [31:0] d, output bit st);
    exp_t nxt;
    if_valid_i = v;
    if_instr_i = ins;
    if_npc_i   = 8'($urandom);
    ex_flush_i = fl;
    wb_we_i    = we;
    wb_rd_i    = rd;
    wb_data_i  = d;
    #1;
    st = m_stall(v, ins, fl);
    chk("id_stall", 32'(id_stall_o), 32'(st));
    nxt = '{default: '0};
    if (v && !fl && !st) nxt = m_decode(ins, if_npc_i);
    @(posedge clk_i);
    if (we && rd != 5'd0) m_rf[rd] = d;
    m_ex = nxt;
    exp_q.push_back(nxt);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_id_stall"}, 32'(id_stall_o), 32'd0);
    chk({tag, "_ex_valid"}, 32'(ex_valid_o), 32'd0);
    chk({tag, "_ex_npc"}, 32'(ex_npc_o), 32'd0);
    chk({tag, "_ex_rs_data"}, ex_rs_data_o, 32'd0);
    chk({tag, "_ex_rt_data"}, ex_rt_data_o, 32'd0);
    chk({tag, "_ex_imm"}, ex_imm_o, 32'd0);
    chk({tag, "_ex_ctrl"}, 32'({ex_rd_o, ex_alu_func_o, ex_use_imm_o, ex_mem_rd_o, ex_mem_wr_o,
                                ex_branch_o, ex_branch_z_o, ex_illegal_o}), 32'd0);
    chk({tag, "_ex_br_target"}, 32'(ex_br_target_o), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", 32'(ex_valid_o), 32'(e.valid));
        chk("ex_npc", 32'(ex_npc_o), 32'(e.npc));
        chk("ex_rs_data", ex_rs_data_o, e.rs_data);
        chk("ex_rt_data", ex_rt_data_o, e.rt_data);
        chk("ex_imm", ex_imm_o, e.imm);
        chk("ex_rd", 32'(ex_rd_o), 32'(e.rd));
        chk("ex_alu_func", 32'(ex_alu_func_o), 32'(e.func));
        chk("ex_use_imm", 32'(ex_use_imm_o), 32'(e.use_imm));
        chk("ex_mem_rd", 32'(ex_mem_rd_o), 32'(e.mem_rd));
        chk("ex_mem_wr", 32'(ex_mem_wr_o), 32'(e.mem_wr));
        chk("ex_branch", 32'(ex_branch_o), 32'(e.branch));
        chk("ex_branch_z", 32'(ex_branch_z_o), 32'(e.branch_z));
        chk("ex_br_target", 32'(ex_br_target_o), 32'(e.target));
        chk("ex_illegal", 32'(ex_illegal_o), 32'(e.illegal));
      end
    end
  end

  initial begin : stimulus
    bit          st;
    bit          v;
    logic [31:0] ins;
    logic [5:0]  op;
    int          r;
    st = 1'b0;
    v = 1'b0;
    ins = '0;
    rst_ni = 1'b0;
    if_valid_i = 1'b0;
    if_instr_i = '0;
    if_npc_i = '0;
    ex_flush_i = 1'b0;
    wb_we_i = 1'b0;
    wb_rd_i = '0;
    wb_data_i = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ex = '{default: '0};
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    rst_ni = 1'b1;

    // Write then read, r0 operand
    step(0, '0, 0, 1, 5'd5, 32'h0000_1234, st);
    step(1, mk(6'd0, 5'd5, 5'd0, 16'h0020), 0, 0, 5'd0, 32'd0, st);
    // ALUI sign extension
    step(1, mk(6'd1, 5'd5, 5'd9, 16'h8001), 0, 0, 5'd0, 32'd0, st);
    // Load-use: LD r3 then ALU rs=3, re-presented while stalled
    step(1, mk(6'd2, 5'd1, 5'd3, 16'h0004), 0, 0, 5'd0, 32'd0, st);
    step(1, mk(6'd0, 5'd3, 5'd4, 16'h0022), 0, 0, 5'd0, 32'd0, st);
    step(1, mk(6'd0, 5'd3, 5'd4, 16'h0022), 0, 0, 5'd0, 32'd0, st);
    // Same hazard with a flush in the stall cycle
    step(1, mk(6'd2, 5'd1, 5'd3, 16'h0004), 0, 0, 5'd0, 32'd0, st);
    step(1, mk(6'd0, 5'd3, 5'd4, 16'h0022), 1, 0, 5'd0, 32'd0, st);
    // r0 write ignored, then same-cycle writeback/read of r7
    step(0, '0, 0, 1, 5'd0, 32'hFFFF_FFFF, st);
    step(1, mk(6'd0, 5'd0, 5'd0, 16'h0020), 0, 1, 5'd7, 32'h0000_0011, st);
    step(1, mk(6'd0, 5'd7, 5'd7, 16'h0020), 0, 1, 5'd7, 32'h0000_00A5, st);
    // Illegal opcode and both branch flavours
    step(1, mk(6'h3F, 5'd7, 5'd5, 16'h1234), 0, 0, 5'd0, 32'd0, st);
    step(1, mk(6'd4, 5'd0, 5'd0, 16'h00C8), 0, 0, 5'd0, 32'd0, st);
    step(1, mk(6'd5, 5'd7, 5'd0, 16'hFF10), 0, 0, 5'd0, 32'd0, st);
    step(1, mk(6'd3, 5'd5, 5'd7, 16'h0010), 0, 0, 5'd0, 32'd0, st);
    chk("pre_reset_ex_valid", 32'(ex_valid_o), 32'd1);

    // Asynchronous reset between clock edges while ex_valid=1
    #2;
    exp_q.delete();
    rst_ni = 1'b0;
    #1;
    chk_all_zero("async_reset");
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ex = '{default: '0};
    if_valid_i = 1'b0;
    wb_we_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(1, mk(6'd0, 5'd5, 5'd7, 16'h0020), 0, 0, 5'd0, 32'd0, st);

    st = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!st) begin
        v = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 13);
        if (r < 12)       op = 6'(r / 2);
        else if (r == 12) op = 6'h3F;
        else              op = 6'($urandom);
        ins = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      end
      step(v, ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), $urandom, st);
    end
    step(0, '0, 0, 0, 5'd0, 32'd0, st);

    repeat (2) @(posedge clk_i);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
